pong_game_ctrl: RTL and testbench

Game-sequencing controller for the pong datapath. It owns the match state (attract/idle, serve countdown, rally, point pause, game over) and the two player scores. It drives the ball-motion enable and ball-recenter controls of the pong datapath, counting time in video frames taken from the vsync output of `hvsync_generator`. It sits beside `pong` inside the top level and shares its `clk` and `reset`.

---
 rtl/pong_game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for the pong datapath.
// Tracks match state (idle, serve countdown, rally, point pause, game over)
// and both scores. It drives the ball enable/recenter controls, timing
// everything in video frames derived from vsync.
//
// Ports:
//   clk, reset              pixel clock, synchronous active-high reset
//   vsync                   vertical sync, rising edge = one frame tick
//   start                   debounced start button level
//   miss_left, miss_right   ball passed left / right paddle
//   ball_enable, ball_reset ball motion enable / hold-at-centre
//   serve_dir               0 = serve left, 1 = serve right
//   score1, score2          player scores
//   game_over, winner       match finished / winning player (0 = p1, 1 = p2)
//   state                   current FSM state (debug)
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_enable,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam int MAXF = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CW   = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam logic [CW-1:0] SERVE_LD = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] POINT_LD = CW'(POINT_FRAMES - 1);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    score1_q, score1_d, score2_q, score2_d;
  logic          dir_q, dir_d;
  logic          winner_q, winner_d;
  logic          ball_enable_q, ball_reset_q, game_over_q;
  logic          vsync_q, start_q;
  logic          tick_q, start_edge_q;

  // Edge pulses are registered so the FSM sees a clean one-cycle event.
  // start_q tracks start even during reset: a button held through reset
  // must not look like a fresh press once reset drops.
  always_ff @(posedge clk) begin
    start_q <= start;
    if (reset) begin
      vsync_q       <= 1'b0;
      tick_q        <= 1'b0;
      start_edge_q  <= 1'b0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      score1_q      <= 4'd0;
      score2_q      <= 4'd0;
      dir_q         <= 1'b0;
      winner_q      <= 1'b0;
      ball_enable_q <= 1'b0;
      ball_reset_q  <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      tick_q        <= vsync & ~vsync_q;
      start_edge_q  <= start & ~start_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      dir_q         <= dir_d;
      winner_q      <= winner_d;
      ball_enable_q <= (state_d == S_PLAY);
      ball_reset_q  <= (state_d == S_IDLE) || (state_d == S_SERVE) || (state_d == S_OVER);
      game_over_q   <= (state_d == S_OVER);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    dir_d    = dir_q;
    winner_d = winner_q;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge_q) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          dir_d    = 1'b0;
          cnt_d    = SERVE_LD;
          state_d  = S_SERVE;
        end
      end
      S_SERVE: begin
        if (tick_q) begin
          if (cnt_q == '0) state_d = S_PLAY;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_PLAY: begin
        // Frame ticks have no effect here; only misses move the FSM.
        if (miss_left || miss_right) begin
          cnt_d   = POINT_LD;
          state_d = S_POINT;
          if (miss_left && !miss_right) begin
            score2_d = score2_q + 4'd1;
            dir_d    = 1'b0;
            if (score2_q + 4'd1 == WIN) begin
              state_d  = S_OVER;
              winner_d = 1'b1;
            end
          end else if (miss_right && !miss_left) begin
            score1_d = score1_q + 4'd1;
            dir_d    = 1'b1;
            if (score1_q + 4'd1 == WIN) begin
              state_d  = S_OVER;
              winner_d = 1'b0;
            end
          end else begin
            // Simultaneous misses: nobody scores, serve side flips.
            dir_d = ~dir_q;
          end
        end
      end
      S_POINT: begin
        if (tick_q) begin
          if (cnt_q == '0) begin
            cnt_d   = SERVE_LD;
            state_d = S_SERVE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state       = state_q;
  assign ball_enable = ball_enable_q;
  assign ball_reset  = ball_reset_q;
  assign serve_dir   = dir_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with default frame counts.
// Inputs change right after a falling edge; outputs are checked on falling edges.
module tb_pong_game_ctrl;
  localparam int SF = 60;
  localparam int PF = 30;

  logic       clk = 1'b0;
  logic       reset, vsync, start, miss_left, miss_right;
  logic       ball_enable, ball_reset, serve_dir, game_over, winner;
  logic [3:0] score1, score2;
  logic [2:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  pong_game_ctrl #(.SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(7)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
    .ball_enable(ball_enable), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score1(score1), .score2(score2), .game_over(game_over), .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One video frame: vsync high 2 cycles, low 2 cycles. The tick is fully
  // absorbed by the FSM before the task returns.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1; cyc(2);
      vsync = 1'b0; cyc(2);
    end
  endtask

  task automatic pulse_ml();
    miss_left = 1'b1; cyc(1); miss_left = 1'b0;
  endtask

  task automatic pulse_mr();
    miss_right = 1'b1; cyc(1); miss_right = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    cyc(3);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_ball_reset", 8'(ball_reset), 8'd1);
    chk("rst_ball_enable", 8'(ball_enable), 8'd0);
    chk("rst_score1", 8'(score1), 8'd0);
    chk("rst_score2", 8'(score2), 8'd0);
    chk("rst_game_over", 8'(game_over), 8'd0);
    chk("rst_winner", 8'(winner), 8'd0);
    chk("rst_serve_dir", 8'(serve_dir), 8'd0);
    reset = 1'b0;
    cyc(2);
    chk("idle_hold", 8'(state), 8'd0);

    // Start press: SERVE appears two cycles after the rise.
    start = 1'b1;
    cyc(1); chk("start_lat1", 8'(state), 8'd0);
    cyc(1); chk("start_lat2", 8'(state), 8'd1);
    chk("serve_ball_reset", 8'(ball_reset), 8'd1);
    chk("serve_score1", 8'(score1), 8'd0);
    start = 1'b0;
    frames(SF - 1);
    chk("serve_59", 8'(state), 8'd1);
    frames(1);
    chk("serve_60_state", 8'(state), 8'd2);
    chk("play_ball_enable", 8'(ball_enable), 8'd1);
    chk("play_ball_reset", 8'(ball_reset), 8'd0);

    // miss_left pulse.
    pulse_ml();
    chk("ml_state", 8'(state), 8'd3);
    chk("ml_score2", 8'(score2), 8'd1);
    chk("ml_dir", 8'(serve_dir), 8'd0);
    chk("point_ball_enable", 8'(ball_enable), 8'd0);
    chk("point_ball_reset", 8'(ball_reset), 8'd0);
    frames(PF - 1);
    chk("point_29", 8'(state), 8'd3);
    frames(1);
    chk("point_30", 8'(state), 8'd1);
    frames(SF);
    chk("replay", 8'(state), 8'd2);

    // miss_right in the same cycle as a frame tick: miss wins, tick ignored.
    vsync = 1'b1; cyc(1);
    miss_right = 1'b1; cyc(1);
    miss_right = 1'b0; vsync = 1'b0; cyc(2);
    chk("mr_tick_state", 8'(state), 8'd3);
    chk("mr_tick_score1", 8'(score1), 8'd1);
    chk("mr_tick_dir", 8'(serve_dir), 8'd1);
    frames(PF - 1);
    chk("mr_point_29", 8'(state), 8'd3);
    frames(1);
    chk("mr_point_30", 8'(state), 8'd1);
    frames(SF);

    // Both misses together with serve_dir = 1.
    miss_left = 1'b1; miss_right = 1'b1; cyc(1);
    miss_left = 1'b0; miss_right = 1'b0;
    chk("both_state", 8'(state), 8'd3);
    chk("both_score1", 8'(score1), 8'd1);
    chk("both_score2", 8'(score2), 8'd1);
    chk("both_dir", 8'(serve_dir), 8'd0);
    frames(PF + SF);
    chk("both_replay", 8'(state), 8'd2);

    // Long miss_right level scores once.
    miss_right = 1'b1; cyc(500); miss_right = 1'b0;
    chk("hold_score1", 8'(score1), 8'd2);
    chk("hold_state", 8'(state), 8'd3);
    frames(PF + SF);

    for (int i = 0; i < 4; i++) begin
      pulse_mr();
      frames(PF + SF);
    end
    chk("six_score1", 8'(score1), 8'd6);
    chk("six_state", 8'(state), 8'd2);

    // Winning point.
    pulse_mr();
    chk("win_score1", 8'(score1), 8'd7);
    chk("win_state", 8'(state), 8'd4);
    chk("win_game_over", 8'(game_over), 8'd1);
    chk("win_winner", 8'(winner), 8'd0);
    chk("over_ball_reset", 8'(ball_reset), 8'd1);
    chk("over_ball_enable", 8'(ball_enable), 8'd0);
    pulse_ml(); pulse_mr(); cyc(2);
    chk("over_score1", 8'(score1), 8'd7);
    chk("over_score2", 8'(score2), 8'd1);
    chk("over_state", 8'(state), 8'd4);

    // Restart from OVER.
    start = 1'b1; cyc(2);
    chk("restart_state", 8'(state), 8'd1);
    chk("restart_score1", 8'(score1), 8'd0);
    chk("restart_score2", 8'(score2), 8'd0);
    chk("restart_game_over", 8'(game_over), 8'd0);
    chk("restart_dir", 8'(serve_dir), 8'd0);
    start = 1'b0;
    frames(SF);
    pulse_ml(); frames(PF + SF);
    pulse_ml(); frames(PF + SF);
    pulse_ml();
    chk("pre_rst_score2", 8'(score2), 8'd3);
    chk("pre_rst_state", 8'(state), 8'd3);

    // Reset during POINT with start held through it.
    reset = 1'b1; start = 1'b1; cyc(1);
    chk("mid_rst_state", 8'(state), 8'd0);
    chk("mid_rst_score1", 8'(score1), 8'd0);
    chk("mid_rst_score2", 8'(score2), 8'd0);
    chk("mid_rst_ball_reset", 8'(ball_reset), 8'd1);
    reset = 1'b0; cyc(10);
    chk("held_start_no_serve", 8'(state), 8'd0);
    start = 1'b0; cyc(2);
    start = 1'b1;
    cyc(1); chk("repress_lat1", 8'(state), 8'd0);
    cyc(1); chk("repress_lat2", 8'(state), 8'd1);
    start = 1'b0; cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
